// File: rtl/key_exp_ctrl.sv
// AES-128 key-expansion controller: walks the 11 round keys, borrowing a byte-serial s_box
// through an enable/done handshake to form SubWord(RotWord(w3)) for each round.
module key_exp_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         sbox_enable,
  output logic [7:0]   sbox_data_in,
  input  logic [7:0]   sbox_data_out,
  input  logic         sbox_done
);

  typedef enum logic [2:0] {StIdle, StEmit, StSubReq, StSubWait, StMix} state_e;

  state_e       state_q, state_d;
  logic [127:0] cur_key_q, cur_key_d;
  logic [31:0]  temp_q, temp_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_round_q, rk_round_d;

  logic [31:0] w0, w1, w2, w3, rot_word, t_word, w0_n, w1_n, w2_n, w3_n;

  assign w0       = cur_key_q[127:96];
  assign w1       = cur_key_q[95:64];
  assign w2       = cur_key_q[63:32];
  assign w3       = cur_key_q[31:0];
  assign rot_word = {w3[23:0], w3[31:24]};
  assign t_word   = temp_q ^ {rcon_q, 24'h0};
  assign w0_n     = w0 ^ t_word;
  assign w1_n     = w1 ^ w0_n;
  assign w2_n     = w2 ^ w1_n;
  assign w3_n     = w3 ^ w2_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_key_q  <= '0;
      temp_q     <= '0;
      byte_idx_q <= '0;
      round_q    <= '0;
      rcon_q     <= '0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_key_q  <= cur_key_d;
      temp_q     <= temp_d;
      byte_idx_q <= byte_idx_d;
      round_q    <= round_d;
      rcon_q     <= rcon_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_key_d  = cur_key_q;
    temp_d     = temp_q;
    byte_idx_d = byte_idx_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_key_d = key_in;
          round_d   = 4'd0;
          rcon_d    = 8'h01;
          state_d   = StEmit;
        end
      end
      StEmit: begin
        rk_data_d  = cur_key_q;
        rk_round_d = round_q;
        if (round_q == 4'd10) begin
          state_d = StIdle;
        end else begin
          byte_idx_d = 2'd0;
          state_d    = StSubReq;
        end
      end
      StSubReq: state_d = StSubWait;
      StSubWait: begin
        if (sbox_done) begin
          // Byte 0 lands in the MSB so temp ends up as SubWord(RotWord(w3)).
          case (byte_idx_q)
            2'd0:    temp_d[31:24] = sbox_data_out;
            2'd1:    temp_d[23:16] = sbox_data_out;
            2'd2:    temp_d[15:8]  = sbox_data_out;
            default: temp_d[7:0]   = sbox_data_out;
          endcase
          if (byte_idx_q == 2'd3) begin
            state_d = StMix;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = StSubReq;
          end
        end
      end
      StMix: begin
        cur_key_d = {w0_n, w1_n, w2_n, w3_n};
        round_d   = round_q + 4'd1;
        rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        state_d   = StEmit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q != StIdle);
    rk_valid     = (state_q == StEmit);
    done         = (state_q == StEmit) && (round_q == 4'd10);
    sbox_enable  = (state_q == StSubReq);
    sbox_data_in = 8'h00;
    if (state_q == StSubReq) begin
      case (byte_idx_q)
        2'd0:    sbox_data_in = rot_word[31:24];
        2'd1:    sbox_data_in = rot_word[23:16];
        2'd2:    sbox_data_in = rot_word[15:8];
        default: sbox_data_in = rot_word[7:0];
      endcase
    end
    // The pulse cycle shows the live key; the registered copy holds it afterwards.
    rk_data  = (state_q == StEmit) ? cur_key_q : rk_data_q;
    rk_round = (state_q == StEmit) ? round_q : rk_round_q;
  end

endmodule

// File: tb/tb_key_exp_ctrl.sv
// Randomised self-checking bench for key_exp_ctrl against a word-level FIPS-197 key schedule,
// with a behavioural byte-serial s_box whose latency and spurious strobes are configurable.
module tb_key_exp_ctrl;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] key_in;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         sbox_enable, sbox_done;
  logic [7:0]   sbox_data_in, sbox_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];

  logic [127:0] rk_d_q [$];
  int           rk_r_q [$];
  int           rk_t_q [$];
  bit           rk_done_q [$];
  logic [7:0]   sb_in_q [$];

  bit         rand_mode = 1'b0;
  bit         pending   = 1'b0;
  int         rem       = 0;
  logic [7:0] pend_byte = 8'h00;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_exp_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_in       (key_in),
    .busy         (busy),
    .done         (done),
    .rk_valid     (rk_valid),
    .rk_round     (rk_round),
    .rk_data      (rk_data),
    .sbox_enable  (sbox_enable),
    .sbox_data_in (sbox_data_in),
    .sbox_data_out(sbox_data_out),
    .sbox_done    (sbox_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(negedge clk) begin
    if (rk_valid) begin
      rk_d_q.push_back(rk_data);
      rk_r_q.push_back(int'(rk_round));
      rk_t_q.push_back(cyc);
      rk_done_q.push_back(done);
    end else begin
      check("done_without_rk_valid", 128'(done), 128'(0));
    end
  end

  // Behavioural s_box: answers D cycles after a request; may also strobe spuriously when idle.
  always @(negedge clk) begin
    sbox_done     = 1'b0;
    sbox_data_out = 8'h00;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        rem--;
        if (rem == 0) begin
          sbox_done     = 1'b1;
          sbox_data_out = sbox_tab[pend_byte];
          pending       = 1'b0;
        end
      end else if (rand_mode && $urandom_range(0, 2) == 0) begin
        sbox_done     = 1'b1;
        sbox_data_out = 8'($urandom);
      end
      if (sbox_enable) begin
        check("sbox_single_outstanding", 128'(pending), 128'(0));
        pending   = 1'b1;
        rem       = rand_mode ? int'($urandom_range(1, 5)) : 1;
        pend_byte = sbox_data_in;
        sb_in_q.push_back(sbox_data_in);
      end else begin
        check("sbox_data_in_idle", 128'(sbox_data_in), 128'(0));
      end
    end
  end

  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    check("idle_before_start", 128'(busy), 128'(0));
    rk_d_q.delete();
    rk_r_q.delete();
    rk_t_q.delete();
    rk_done_q.delete();
    sb_in_q.delete();
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_run();
    int g = 0;
    while (rk_d_q.size() < 11 && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("run_completes", 128'(rk_d_q.size() >= 11), 128'(1));
  endtask

  task automatic verify(input logic [127:0] k, input bit timed);
    expand(k);
    check("rk_count", 128'(rk_d_q.size()), 128'(11));
    for (int r = 0; r < 11 && r < rk_d_q.size(); r++) begin
      check($sformatf("rk_data_r%0d", r), rk_d_q[r], model_rk[r]);
      check($sformatf("rk_round_r%0d", r), 128'(rk_r_q[r]), 128'(r));
      check($sformatf("done_r%0d", r), 128'(rk_done_q[r]), 128'(r == 10));
      if (timed) check($sformatf("rk_time_r%0d", r), 128'(rk_t_q[r] - t0), 128'(10 * r));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_rk_round"}, 128'(rk_round), 128'(0));
    check({tag, "_rk_data"}, rk_data, 128'(0));
    check({tag, "_sbox_enable"}, 128'(sbox_enable), 128'(0));
    check({tag, "_sbox_data_in"}, 128'(sbox_data_in), 128'(0));
  endtask

  initial begin
    logic [127:0] k1, k2, k3;
    int           n_rk, n_sb, g;
    reset  = 1'b1;
    start  = 1'b0;
    key_in = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // FIPS-197 key, unit latency s_box
    kick(FipsKey);
    wait_run();
    verify(FipsKey, 1'b1);
    check("fips_r0", rk_d_q.size() > 0 ? rk_d_q[0] : 'x, FipsKey);
    check("fips_r1", rk_d_q.size() > 1 ? rk_d_q[1] : 'x, 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", rk_d_q.size() > 10 ? rk_d_q[10] : 'x,
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_sbin0", 128'(sb_in_q.size() > 3 ? sb_in_q[0] : 8'hxx), 128'h0cf);
    check("fips_sbin1", 128'(sb_in_q.size() > 3 ? sb_in_q[1] : 8'hxx), 128'h04f);
    check("fips_sbin2", 128'(sb_in_q.size() > 3 ? sb_in_q[2] : 8'hxx), 128'h03c);
    check("fips_sbin3", 128'(sb_in_q.size() > 3 ? sb_in_q[3] : 8'hxx), 128'h009);

    // All-zero key, and no twelfth pulse afterwards
    kick('0);
    wait_run();
    verify('0, 1'b1);
    check("zero_r1", rk_d_q.size() > 1 ? rk_d_q[1] : 'x, 128'h62636363626363636263636362636363);
    check("zero_r10", rk_d_q.size() > 10 ? rk_d_q[10] : 'x,
          128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    repeat (30) @(negedge clk);
    check("zero_pulse_total", 128'(rk_d_q.size()), 128'(11));
    check("zero_idle_after", 128'(busy), 128'(0));

    // Random s_box latency and spurious strobes
    rand_mode = 1'b1;
    kick(FipsKey);
    wait_run();
    verify(FipsKey, 1'b0);
    for (int i = 0; i < 3; i++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      kick(k1);
      wait_run();
      verify(k1, 1'b0);
    end
    rand_mode = 1'b0;
    repeat (10) @(negedge clk);

    // start while busy is ignored, then back-to-back restart
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    k3 = {$urandom, $urandom, $urandom, $urandom};
    kick(k1);
    repeat (15) @(negedge clk);
    start  = 1'b1;
    key_in = k2;
    @(negedge clk);
    start = 1'b0;
    wait_run();
    verify(k1, 1'b1);
    kick(k3);
    wait_run();
    verify(k3, 1'b1);

    // Reset during SUB_WAIT of round 5
    kick(FipsKey);
    g = 0;
    while (rk_d_q.size() < 6 && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    n_sb = sb_in_q.size();
    while (sb_in_q.size() == n_sb && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("reached_round5_sub", 128'(g < 1000), 128'(1));
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("midrun_reset");
    n_rk  = rk_d_q.size();
    n_sb  = sb_in_q.size();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_rk_after_reset", 128'(rk_d_q.size()), 128'(n_rk));
    check("no_sbox_after_reset", 128'(sb_in_q.size()), 128'(n_sb));
    kick(FipsKey);
    wait_run();
    verify(FipsKey, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_exp_ctrl.md
# key_exp_ctrl

Sequential AES-128 key-expansion controller: it takes a 128-bit cipher key and emits the 11 round keys in order, one per `rk_valid` pulse. It sits directly upstream of the byte-serial `s_box` stage in `key_exp`. It feeds that stage one byte per request through an enable/done handshake and consumes each substituted byte to build SubWord(RotWord(w3)). Round keys go to the cipher datapath downstream.

## Interface
Parameters: none. AES-128 only: Nk = 4, 10 rounds.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin expansion of `key_in`. Sampled only when `busy`=0.
- `key_in` in 128: cipher key. `key_in[127:96]` = w0 (first key byte in `[127:120]`).
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse, coincident with the round-10 `rk_valid`.
- `rk_valid` out 1: one-cycle pulse, `rk_data`/`rk_round` valid.
- `rk_round` out 4: round index 0..10. Holds its value between pulses.
- `rk_data` out 128: round key {w0,w1,w2,w3}. Holds its value between pulses.
- `sbox_enable` out 1: one-cycle request pulse to `s_box`.
- `sbox_data_in` out 8: byte to substitute. Valid while `sbox_enable`=1.
- `sbox_data_out` in 8: substituted byte. Valid while `sbox_done`=1.
- `sbox_done` in 1: `s_box` result strobe.

## Operation
- Registers: `cur_key[127:0]`, `temp[31:0]`, `byte_idx[1:0]`, `round[3:0]`, `rcon[7:0]`.
- States: IDLE, EMIT, SUB_REQ, SUB_WAIT, MIX.
- IDLE: if `start`, then `cur_key`←`key_in`, `round`←0, `rcon`←8'h01, go to EMIT. Otherwise stay.
- EMIT: `rk_valid`=1, `rk_data`←`cur_key`, `rk_round`←`round`.
  - If `round`=10: assert `done`, go to IDLE.
  - Otherwise `byte_idx`←0, go to SUB_REQ.
- SUB_REQ: `sbox_enable`=1. `sbox_data_in` = byte `byte_idx` of RotWord(w3) = {w3[23:0],w3[31:24]}, taking byte 0 from the MSB. So the byte order is w3[23:16], w3[15:8], w3[7:0], w3[31:24]. Go to SUB_WAIT.
- SUB_WAIT: hold until `sbox_done`=1, then store `sbox_data_out` into `temp` byte `byte_idx` (byte 0 = `temp[31:24]`).
  - If `byte_idx`=3, go to MIX.
  - Otherwise increment `byte_idx` and go to SUB_REQ.
  - There is no timeout.
- MIX (single cycle):
  - t = `temp` ^ {`rcon`,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - `round`++.
  - `rcon`←xtime(`rcon`) = {rcon[6:0],0} ^ (rcon[7] ? 8'h1B : 0).
  - Go to EMIT.
- `rcon` sequence used by rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- `busy`=1 in every state except IDLE.
- `start` while `busy`=1 is ignored. `key_in` is sampled only at accept; later changes have no effect.
- `sbox_done` outside SUB_WAIT is ignored.
- At most one `s_box` request is outstanding. `sbox_enable` never reasserts before `sbox_done` is received.
- `sbox_data_in` = 0 when `sbox_enable`=0.

## Timing
- Reset values: `busy`, `done`, `rk_valid`, `sbox_enable` = 0. `rk_round`, `rk_data`, `sbox_data_in`, and all internal registers = 0. State = IDLE.
- Reset asserted mid-operation: the next cycle is IDLE with reset values. No further `rk_valid` or `sbox_enable`. The in-flight `sbox_done` is ignored.
- `start` sampled at edge N: `rk_valid` (round 0) and `busy` are high in cycle N+1.
- Let D = cycles from `sbox_enable` to `sbox_done`, with D ≥ 1.
  - Per byte: 1 + D cycles.
  - Per round: 1 (EMIT) + 4(1+D) + 1 (MIX) = 6 + 4D cycles.
- With D=1, round r is emitted in cycle N+1+10r. Round 10 plus `done` come at N+101. `busy` falls at N+102.
- A new `start` is accepted in the first cycle `busy`=0 (N+102 at D=1).

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, behavioural `s_box` with D=1:
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done` at N+101;
  - first four `sbox_data_in` = cf, 4f, 3c, 09.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - exactly 11 `rk_valid` pulses, with `rk_round` 0..10.
- Random D in 1..5 per byte, plus spurious `sbox_done` pulses outside SUB_WAIT: round keys are identical to the D=1 run, and `sbox_enable` never overlaps an outstanding request.
- Re-pulse `start` with a different `key_in` while `busy`: it is ignored and the outputs match the original key. A `start` at N+102 is accepted and round 0 appears at N+103.
- Assert `reset` during SUB_WAIT of round 5: all outputs are 0 the next cycle. A fresh `start` then yields the correct full FIPS-197 sequence.
